// File: rtl/multicycle_control.sv
// Moore control FSM for a shared-memory multicycle MIPS datapath.
// Define CTRL_BLTGT_EN to add blt (000110) / bgt (000111) branches.
module multicycle_control #(
    parameter int unsigned ALUOP_W         = 4,
    parameter int unsigned TRAP_ON_ILLEGAL = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         Opcode,
    input  logic [5:0]         func,
    input  logic               Zero,
    input  logic               lt,
    input  logic               gt,
    input  logic               mem_ready,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ior_d,
    output logic               ir_write,
    output logic               pc_write,
    output logic [1:0]         pc_source,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               illegal,
    output logic [3:0]         state_o
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StAluWb  = 4'd7,
        StBranch = 4'd8,
        StJump   = 4'd9,
        StTrap   = 4'd10
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpSlti  = 6'b001010;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
`ifdef CTRL_BLTGT_EN
    localparam logic [5:0] OpBlt   = 6'b000110;
    localparam logic [5:0] OpBgt   = 6'b000111;
`endif

    localparam logic [5:0] FnAdd = 6'b100000;
    localparam logic [5:0] FnSub = 6'b100010;
    localparam logic [5:0] FnAnd = 6'b100100;
    localparam logic [5:0] FnOr  = 6'b100101;
    localparam logic [5:0] FnSlt = 6'b101010;

    localparam logic [3:0] AluAdd = 4'b0000;
    localparam logic [3:0] AluSub = 4'b0001;
    localparam logic [3:0] AluAnd = 4'b0010;
    localparam logic [3:0] AluOr  = 4'b0011;
    localparam logic [3:0] AluSlt = 4'b0101;

    state_e     state_q, state_d, dec_target;
    logic [5:0] op_q, op_d;
    logic [5:0] func_q, func_d;
    logic       illegal_q, illegal_d;
    logic       dec_legal;
    logic [3:0] alu_code;

`ifndef CTRL_BLTGT_EN
    logic unused_ltgt;
    assign unused_ltgt = lt ^ gt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StFetch;
            op_q      <= '0;
            func_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            func_q    <= func_d;
            illegal_q <= illegal_d;
        end
    end

    // Dispatch from the live IR fields; only consulted while in StDecode.
    always_comb begin
        dec_legal  = 1'b1;
        dec_target = StFetch;
        case (Opcode)
            OpRtype: begin
                dec_target = StExec;
                dec_legal  = func inside {FnAdd, FnSub, FnAnd, FnOr, FnSlt};
            end
            OpLw, OpSw:                     dec_target = StMemAdr;
            OpAddi, OpSlti, OpAndi, OpOri:  dec_target = StExec;
            OpBeq, OpBne:                   dec_target = StBranch;
`ifdef CTRL_BLTGT_EN
            OpBlt, OpBgt:                   dec_target = StBranch;
`endif
            OpJ:                            dec_target = StJump;
            default:                        dec_legal  = 1'b0;
        endcase
        if (!dec_legal) begin
            dec_target = (TRAP_ON_ILLEGAL != 0) ? StTrap : StFetch;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        func_d  = func_q;
        case (state_q)
            StFetch:  if (mem_ready) state_d = StDecode;
            StDecode: begin
                state_d = dec_target;
                op_d    = Opcode;
                func_d  = func;
            end
            StMemAdr: state_d = (op_q == OpSw) ? StMemWr : StMemRd;
            StMemRd:  if (mem_ready) state_d = StMemWb;
            StMemWb:  state_d = StFetch;
            StMemWr:  if (mem_ready) state_d = StFetch;
            StExec:   state_d = StAluWb;
            StAluWb:  state_d = StFetch;
            StBranch: state_d = StFetch;
            StJump:   state_d = StFetch;
            StTrap:   state_d = StTrap;
            default:  state_d = StFetch;
        endcase
        illegal_d = illegal_q | (state_d == StTrap);
    end

    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ior_d      = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_source  = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_code   = AluAdd;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        if (!rst) begin
            case (state_q)
                StFetch: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                StDecode: alu_src_b = 2'b11;
                StMemAdr: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                StMemRd: begin
                    mem_read = 1'b1;
                    ior_d    = 1'b1;
                end
                StMemWb: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                StMemWr: begin
                    mem_write = 1'b1;
                    ior_d     = 1'b1;
                end
                StExec: begin
                    alu_src_a = 1'b1;
                    if (op_q == OpRtype) begin
                        case (func_q)
                            FnSub:   alu_code = AluSub;
                            FnAnd:   alu_code = AluAnd;
                            FnOr:    alu_code = AluOr;
                            FnSlt:   alu_code = AluSlt;
                            default: alu_code = AluAdd;
                        endcase
                    end else begin
                        alu_src_b = 2'b10;
                        case (op_q)
                            OpSlti:  alu_code = AluSlt;
                            OpAndi:  alu_code = AluAnd;
                            OpOri:   alu_code = AluOr;
                            default: alu_code = AluAdd;
                        endcase
                    end
                end
                StAluWb: begin
                    reg_write = 1'b1;
                    reg_dst   = (op_q == OpRtype);
                end
                StBranch: begin
                    alu_src_a = 1'b1;
                    alu_code  = AluSub;
                    pc_source = 2'b01;
                    case (op_q)
                        OpBeq:   pc_write = Zero;
                        OpBne:   pc_write = ~Zero;
`ifdef CTRL_BLTGT_EN
                        OpBlt:   pc_write = lt;
                        OpBgt:   pc_write = gt;
`endif
                        default: pc_write = 1'b0;
                    endcase
                end
                StJump: begin
                    pc_source = 2'b10;
                    pc_write  = 1'b1;
                end
                default: ;
            endcase
        end
        alu_op = ALUOP_W'(alu_code);
    end

    assign illegal = illegal_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed, table-driven bench for multicycle_control; one record per clock cycle.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst, Zero, lt, gt, mem_ready;
    logic [5:0] Opcode, func;
    logic       mem_read, mem_write, ior_d, ir_write, pc_write;
    logic [1:0] pc_source, alu_src_b;
    logic       alu_src_a, reg_dst, mem_to_reg, reg_write, illegal;
    logic [3:0] alu_op, state_o;

    always #5 clk = ~clk;

    multicycle_control #(.ALUOP_W(4), .TRAP_ON_ILLEGAL(1)) dut (
        .clk(clk), .rst(rst), .Opcode(Opcode), .func(func), .Zero(Zero), .lt(lt), .gt(gt),
        .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write), .ior_d(ior_d),
        .ir_write(ir_write), .pc_write(pc_write), .pc_source(pc_source),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .illegal(illegal), .state_o(state_o)
    );

    typedef struct {
        string       tag;
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        zero;
        logic [1:0]  ltgt;
        logic        rdy;
        logic [21:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   step_no  = 0;

    // Expected word: {state, illegal, mr, mw, iord, irw, pcw, pcs, asa, asb, aluop, rd, m2r, rw}
    function automatic logic [21:0] pk(input int st, input int il, input int mr, input int mw,
                                       input int iord, input int irw, input int pcw,
                                       input int pcs, input int asa, input int asb,
                                       input int aop, input int rd, input int m2r,
                                       input int rw);
        return {4'(st), 1'(il), 1'(mr), 1'(mw), 1'(iord), 1'(irw), 1'(pcw), 2'(pcs),
                1'(asa), 2'(asb), 4'(aop), 1'(rd), 1'(m2r), 1'(rw)};
    endfunction

    function automatic vec_t mk(input string tag, input int r, input int op, input int fn,
                                input int z, input int ltgt, input int rdy,
                                input logic [21:0] exp);
        vec_t v;
        v.tag  = tag;
        v.rst  = 1'(r);
        v.op   = 6'(op);
        v.fn   = 6'(fn);
        v.zero = 1'(z);
        v.ltgt = 2'(ltgt);
        v.rdy  = 1'(rdy);
        v.exp  = exp;
        return v;
    endfunction

    task automatic add(input string tag, input int r, input int op, input int fn, input int z,
                       input int ltgt, input int rdy, input logic [21:0] exp);
        tbl.push_back(mk(tag, r, op, fn, z, ltgt, rdy, exp));
    endtask

    task automatic run_vec(input vec_t v);
        logic [21:0] got;
        rst       = v.rst;
        Opcode    = v.op;
        func      = v.fn;
        Zero      = v.zero;
        lt        = v.ltgt[1];
        gt        = v.ltgt[0];
        mem_ready = v.rdy;
        @(negedge clk);
        got = {state_o, illegal, mem_read, mem_write, ior_d, ir_write, pc_write, pc_source,
               alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write};
        n_checks++;
        if (got !== v.exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got %b required %b", v.tag, step_no, got, v.exp);
        end
        step_no++;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input int r, input int op, input int fn, input int z,
                        input int ltgt, input int rdy, input logic [21:0] exp);
        run_vec(mk(tag, r, op, fn, z, ltgt, rdy, exp));
    endtask

    logic [21:0] e_rst, e_f1, e_f0, e_dec, e_wb_r, e_wb_i, e_madr, e_mrd, e_mwr, e_trap;

    initial begin
        e_rst  = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        e_f1   = pk(0, 0, 1, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0);
        e_f0   = pk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        e_dec  = pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0);
        e_madr = pk(2, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0);
        e_mrd  = pk(3, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        e_mwr  = pk(5, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        e_wb_r = pk(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        e_wb_i = pk(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        e_trap = pk(10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        add("rst",      1, 'h00, 'h20, 0, 0, 1, e_rst);
        add("add_f",    0, 'h00, 'h20, 0, 0, 1, e_f1);
        add("add_d",    0, 'h00, 'h20, 0, 0, 1, e_dec);
        add("add_ex",   0, 'h00, 'h20, 0, 0, 1, pk(6, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        add("add_wb",   0, 'h00, 'h20, 0, 0, 1, e_wb_r);
        add("sub_fw",   0, 'h00, 'h22, 0, 0, 0, e_f0);
        add("sub_f",    0, 'h00, 'h22, 0, 0, 1, e_f1);
        add("sub_d",    0, 'h00, 'h22, 0, 0, 1, e_dec);
        add("sub_ex",   0, 'h00, 'h22, 0, 0, 1, pk(6, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
        add("sub_wb",   0, 'h00, 'h22, 0, 0, 1, e_wb_r);
        add("slt_f",    0, 'h00, 'h2a, 0, 0, 1, e_f1);
        add("slt_d",    0, 'h00, 'h2a, 0, 0, 1, e_dec);
        add("slt_ex",   0, 'h00, 'h2a, 0, 0, 1, pk(6, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5, 0, 0, 0));
        add("slt_wb",   0, 'h00, 'h2a, 0, 0, 1, e_wb_r);
        add("ori_f",    0, 'h0d, 'h00, 0, 0, 1, e_f1);
        add("ori_d",    0, 'h0d, 'h00, 0, 0, 1, e_dec);
        add("ori_ex",   0, 'h0d, 'h00, 0, 0, 1, pk(6, 0, 0, 0, 0, 0, 0, 0, 1, 2, 3, 0, 0, 0));
        add("ori_wb",   0, 'h0d, 'h00, 0, 0, 1, e_wb_i);
        add("andi_f",   0, 'h0c, 'h00, 0, 0, 1, e_f1);
        add("andi_d",   0, 'h0c, 'h00, 0, 0, 1, e_dec);
        add("andi_ex",  0, 'h0c, 'h00, 0, 0, 1, pk(6, 0, 0, 0, 0, 0, 0, 0, 1, 2, 2, 0, 0, 0));
        add("andi_wb",  0, 'h0c, 'h00, 0, 0, 1, e_wb_i);
        add("lw_f",     0, 'h23, 'h00, 0, 0, 1, e_f1);
        add("lw_d",     0, 'h23, 'h00, 0, 0, 1, e_dec);
        add("lw_adr",   0, 'h23, 'h00, 0, 0, 1, e_madr);
        add("lw_wait1", 0, 'h23, 'h00, 0, 0, 0, e_mrd);
        add("lw_wait2", 0, 'h23, 'h00, 0, 0, 0, e_mrd);
        add("lw_rd",    0, 'h23, 'h00, 0, 0, 1, e_mrd);
        add("lw_wb",    0, 'h23, 'h00, 0, 0, 1, pk(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        add("sw_f",     0, 'h2b, 'h00, 0, 0, 1, e_f1);
        add("sw_d",     0, 'h2b, 'h00, 0, 0, 1, e_dec);
        add("sw_adr",   0, 'h2b, 'h00, 0, 0, 1, e_madr);
        add("sw_wr",    0, 'h2b, 'h00, 0, 0, 1, e_mwr);
        add("beq_f",    0, 'h04, 'h00, 1, 0, 1, e_f1);
        add("beq_d",    0, 'h04, 'h00, 1, 0, 1, e_dec);
        add("beq_z1",   0, 'h04, 'h00, 1, 0, 1, pk(8, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0));
        add("bne_f",    0, 'h05, 'h00, 1, 0, 1, e_f1);
        add("bne_d",    0, 'h05, 'h00, 1, 0, 1, e_dec);
        add("bne_z1",   0, 'h05, 'h00, 1, 0, 1, pk(8, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0));
        add("bne2_f",   0, 'h05, 'h00, 0, 0, 1, e_f1);
        add("bne2_d",   0, 'h05, 'h00, 0, 0, 1, e_dec);
        add("bne_z0",   0, 'h05, 'h00, 0, 0, 1, pk(8, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0));
        add("j_f",      0, 'h02, 'h00, 0, 0, 1, e_f1);
        add("j_d",      0, 'h02, 'h00, 0, 0, 1, e_dec);
        add("j_jmp",    0, 'h02, 'h00, 0, 0, 1, pk(9, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0));

        rst = 1'b1; Opcode = '0; func = '0; Zero = 1'b0; lt = 1'b0; gt = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) run_vec(tbl[i]);

        // Reset landing in the middle of a store wait aborts it without a write.
        step("swr_f",    0, 'h2b, 'h00, 0, 0, 1, e_f1);
        step("swr_d",    0, 'h2b, 'h00, 0, 0, 1, e_dec);
        step("swr_adr",  0, 'h2b, 'h00, 0, 0, 1, e_madr);
        step("swr_wait", 0, 'h2b, 'h00, 0, 0, 0, e_mwr);
        step("swr_rst",  1, 'h2b, 'h00, 0, 0, 0, pk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("post_f",   0, 'h02, 'h00, 0, 0, 1, e_f1);
        step("post_d",   0, 'h02, 'h00, 0, 0, 1, e_dec);
        step("post_j",   0, 'h02, 'h00, 0, 0, 1, pk(9, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0));

        // Unknown opcode traps and stays put until reset.
        step("ill_f", 0, 'h3f, 'h00, 0, 0, 1, e_f1);
        step("ill_d", 0, 'h3f, 'h00, 0, 0, 1, e_dec);
        for (int i = 0; i < 10; i++) step("ill_hold", 0, 'h3f, 'h00, 1, 3, 1, e_trap);
        step("ill_rst",   1, 'h3f, 'h00, 0, 0, 1, e_trap);
        step("ill_after", 0, 'h00, 'h20, 0, 0, 1, e_f1);

        // R-type with an undefined func is caught at decode.
        step("fn_d",    0, 'h00, 'h3f, 0, 0, 1, e_dec);
        step("fn_trap", 0, 'h00, 'h3f, 0, 0, 1, e_trap);
        step("fn_rst",  1, 'h00, 'h3f, 0, 0, 1, e_trap);
        step("fn_after", 0, 'h00, 'h20, 0, 0, 1, e_f1);

`ifdef CTRL_BLTGT_EN
        step("blt_d",  0, 'h06, 'h00, 0, 2, 1, e_dec);
        step("blt_br", 0, 'h06, 'h00, 0, 2, 1, pk(8, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0));
        step("bgt_f",  0, 'h07, 'h00, 0, 2, 1, e_f1);
        step("bgt_d",  0, 'h07, 'h00, 0, 2, 1, e_dec);
        step("bgt_br", 0, 'h07, 'h00, 0, 2, 1, pk(8, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0));
        step("bgt2_f", 0, 'h07, 'h00, 0, 1, 1, e_f1);
        step("bgt2_d", 0, 'h07, 'h00, 0, 1, 1, e_dec);
        step("bgt_g1", 0, 'h07, 'h00, 0, 1, 1, pk(8, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0));
`else
        step("blt_d",    0, 'h06, 'h00, 0, 2, 1, e_dec);
        step("blt_trap", 0, 'h06, 'h00, 0, 2, 1, e_trap);
        step("blt_rst",  1, 'h06, 'h00, 0, 2, 1, e_trap);
        step("blt_after", 0, 'h00, 'h20, 0, 0, 1, e_f1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle successor to the single-cycle MIPS main decoder.
- A Moore FSM sequences each instruction over 3–5 states and drives datapath enables, mux selects and ALU op codes.
- Adds a memory ready/wait handshake, internal branch resolution, an illegal-opcode trap and a parametrised ALU op width.
- Sits between the instruction register and the shared-memory multicycle datapath.

Parameters:
- ALUOP_W, 4: width of alu_op. Must be ≥4; codes are zero-extended.
- TRAP_ON_ILLEGAL, 1: 1 = an unknown opcode/func enters S_TRAP; 0 = treated as a NOP and returns to S_FETCH.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- Opcode  in  6  IR[31:26]
- func  in  6  IR[5:0]
- Zero  in  1  ALU zero flag
- lt  in  1  ALU signed less-than (A<B)
- gt  in  1  ALU signed greater-than (A>B)
- mem_ready  in  1  memory completes the access this cycle
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ior_d  out  1  memory address select: 0=PC, 1=ALUOut
- ir_write  out  1  load IR
- pc_write  out  1  unconditional PC load
- pc_source  out  2  00=ALU, 01=ALUOut, 10=jump target
- alu_src_a  out  1  0=PC, 1=A
- alu_src_b  out  2  00=B, 01=4, 10=signext imm, 11=imm<<2
- alu_op  out  ALUOP_W  add=0000, sub=0001, and=0010, or=0011, slt=0101
- reg_dst  out  1  1=rd, 0=rt
- mem_to_reg  out  1  1=MDR, 0=ALUOut
- reg_write  out  1  register file write
- illegal  out  1  sticky; set on entering S_TRAP
- state_o  out  4  current state, for debug

Behaviour:
- Clock/reset: one clock, clk. Reset rst is synchronous and active-high.
- On a rst cycle: state←S_FETCH, op_q/func_q←0, illegal←0.
- While rst is high, every enable (mem_read, mem_write, ir_write, pc_write, reg_write) is forced to 0. Selects are 0 and alu_op=0.
- Outputs are combinational from the registered state and op_q/func_q only. Only S_FETCH's ir_write/pc_write and the branch pc_write also depend on inputs.
- Any signal not listed for a state is 0.
- S_FETCH(0): mem_read=1, ior_d=0, alu_src_b=01, alu_op=add, pc_source=00.
  - If mem_ready: ir_write=1, pc_write=1, go to S_DECODE.
  - Otherwise hold in S_FETCH with ir_write=pc_write=0.
- S_DECODE(1): alu_src_b=11, alu_op=add (branch target into ALUOut). op_q←Opcode, func_q←func. Dispatch on Opcode:
  - 000000 → S_EXEC.
  - 100011 (lw) or 101011 (sw) → S_MEMADR.
  - 001000, 001010, 001100, 001101 (addi, slti, andi, ori) → S_EXEC.
  - 000100 (beq) or 000101 (bne) → S_BRANCH.
  - 000010 (j) → S_JUMP.
  - Anything else → illegal handling.
- R-type with func outside {100000, 100010, 100100, 100101, 101010} is also illegal; it is detected in S_DECODE.
- S_MEMADR(2): alu_src_a=1, alu_src_b=10, alu_op=add. Go to S_MEMRD for lw, S_MEMWR for sw.
- S_MEMRD(3): mem_read=1, ior_d=1. Go to S_MEMWB on mem_ready, else hold.
- S_MEMWB(4): reg_write=1, reg_dst=0, mem_to_reg=1. Go to S_FETCH.
- S_MEMWR(5): mem_write=1, ior_d=1. Go to S_FETCH on mem_ready, else hold.
- S_EXEC(6): alu_src_a=1.
  - R-type: alu_src_b=00, alu_op from func_q.
  - I-type: alu_src_b=10, alu_op = add/slt/and/or for addi/slti/andi/ori.
  - Go to S_ALUWB.
- S_ALUWB(7): reg_write=1, mem_to_reg=0, reg_dst=1 for R-type, 0 for I-type. Go to S_FETCH.
- S_BRANCH(8): alu_src_a=1, alu_src_b=00, alu_op=sub, pc_source=01. Go to S_FETCH.
  - pc_write = Zero for beq, ~Zero for bne.
- S_JUMP(9): pc_source=10, pc_write=1. Go to S_FETCH.
- S_TRAP(10): all enables 0, illegal=1. Held until rst.
- Illegal with TRAP_ON_ILLEGAL=0: S_DECODE goes directly to S_FETCH and illegal stays 0.
- Latency with mem_ready tied to 1: R/I-ALU 4 cycles, lw 5, sw 4, beq/bne 3, j 3. Each mem_ready=0 cycle adds one cycle.
- mem_write and mem_read are never high together. reg_write and pc_write are never high together.
- rst asserted mid-instruction (including during a memory wait) aborts it. No write enable is asserted in the reset cycle.
- Unused state encodings (11–15) go to S_FETCH on the next edge.

Optional Feature:
- Macro: CTRL_BLTGT_EN.
- Defined: opcodes 000110 (blt) and 000111 (bgt) dispatch from S_DECODE to S_BRANCH.
  - In S_BRANCH: pc_write = lt for blt, gt for bgt; alu_op=sub.
- Undefined: both opcodes are illegal. The lt and gt inputs are unused.

Test Plan:
- Reset then R-type add (Opcode 000000, func 100000), mem_ready=1 → states 0,1,6,7,0. alu_op=0000 in S_EXEC. reg_write=1, reg_dst=1 only in S_ALUWB.
- lw with mem_ready low for 2 cycles in S_MEMRD → 7 cycles total. mem_read=1, ior_d=1 held throughout. reg_write=1, mem_to_reg=1 in S_MEMWB.
- beq with Zero=1 → pc_write=1, pc_source=01 in S_BRANCH. bne with Zero=1 → pc_write=0. Each takes 3 cycles.
- Opcode 111111 with TRAP_ON_ILLEGAL=1 → state_o=10, illegal=1, all enables 0 for 10 cycles. rst → state_o=0, illegal=0.
- rst asserted during a sw wait (S_MEMWR, mem_ready=0) → next cycle state_o=0. mem_write=0 during the rst cycle. The next fetch proceeds normally.
- With CTRL_BLTGT_EN defined: blt, lt=1 → pc_write=1. bgt, gt=0 → pc_write=0. Without the macro: opcode 000110 → S_TRAP.
